// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and branch hazards,
// multi-cycle (mul/div) stall FSM with timeout, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W      = 16,
    parameter int MC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1d,
    input  logic [4:0]       rs2d,
    input  logic [4:0]       rs1e,
    input  logic [4:0]       rs2e,
    input  logic [4:0]       rde,
    input  logic [1:0]       resultsrce,
    input  logic             pcsrce,
    input  logic [4:0]       rdm,
    input  logic             regwritem,
    input  logic [4:0]       rdw,
    input  logic             regwritew,
    input  logic             mc_req_e,
    input  logic             mc_done,
    input  logic             clr_cnt,
    output logic             stallf,
    output logic             stalld,
    output logic             stalle,
    output logic             flushd,
    output logic             flushe,
    output logic             flushm,
    output logic [1:0]       forwardae,
    output logic [1:0]       forwardbe,
    output logic             mc_start,
    output logic             mc_busy,
    output logic             mc_valid,
    output logic             mc_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TO_W = $clog2(MC_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_mc_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_lwstall;
    logic w_mc_launch;
    logic w_mcstall;
    logic w_timeout;

    // MEM stage wins over WB because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic wr_m, input logic [4:0] rd_w,
                                           input logic wr_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign forwardae = fwd_sel(rs1e, rdm, regwritem, rdw, regwritew);
    assign forwardbe = fwd_sel(rs2e, rdm, regwritem, rdw, regwritew);

    assign w_lwstall   = (resultsrce == 2'b01) && (rde != 5'd0) &&
                         ((rde == rs1d) || (rde == rs2d));
    assign w_mc_launch = (r_state == S_IDLE) && mc_req_e && !pcsrce;
    assign w_mcstall   = w_mc_launch || (r_state == S_BUSY);
    assign w_timeout   = (r_to_cnt == TO_W'(MC_TIMEOUT - 1));

    assign mc_start = w_mc_launch;
    assign mc_busy  = (r_state == S_BUSY);
    assign mc_valid = (r_state == S_DONE);
    assign mc_err   = r_mc_err;

    // A multi-cycle op freezes the front end and EX, and bubbles MEM; younger hazards wait.
    always_comb begin
        stallf = 1'b0;
        stalld = 1'b0;
        stalle = 1'b0;
        flushd = 1'b0;
        flushe = 1'b0;
        flushm = 1'b0;
        if (w_mcstall) begin
            stallf = 1'b1;
            stalld = 1'b1;
            stalle = 1'b1;
            flushm = 1'b1;
        end else begin
            stallf = w_lwstall;
            stalld = w_lwstall;
            flushd = pcsrce;
            flushe = w_lwstall | pcsrce;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_to_cnt <= '0;
            r_mc_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mc_launch) begin
                        r_state  <= S_BUSY;
                        r_to_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    // A completion arriving on the last allowed cycle is not an error.
                    if (mc_done) begin
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_state  <= S_DONE;
                        r_mc_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stallf && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flushd && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares every cycle.
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;
    localparam int TO = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk, rst_n;
    logic [4:0]    rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0]    resultsrce;
    logic          pcsrce, regwritem, regwritew, mc_req_e, mc_done, clr_cnt;
    logic          stallf, stalld, stalle, flushd, flushe, flushm;
    logic [1:0]    forwardae, forwardbe;
    logic          mc_start, mc_busy, mc_valid, mc_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(CW), .MC_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
        .resultsrce(resultsrce), .pcsrce(pcsrce),
        .rdm(rdm), .regwritem(regwritem), .rdw(rdw), .regwritew(regwritew),
        .mc_req_e(mc_req_e), .mc_done(mc_done), .clr_cnt(clr_cnt),
        .stallf(stallf), .stalld(stalld), .stalle(stalle),
        .flushd(flushd), .flushe(flushe), .flushm(flushm),
        .forwardae(forwardae), .forwardbe(forwardbe),
        .mc_start(mc_start), .mc_busy(mc_busy), .mc_valid(mc_valid), .mc_err(mc_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] resultsrce;
        logic       pcsrce;
        logic [4:0] rdm;
        logic       regwritem;
        logic [4:0] rdw;
        logic       regwritew;
        logic       mc_req_e, mc_done, clr_cnt;
    } in_t;

    typedef struct packed {
        logic          stallf, stalld, stalle, flushd, flushe, flushm;
        logic [1:0]    fa, fb;
        logic          start, busy, valid, err;
        logic [CW-1:0] scnt, fcnt;
    } exp_t;

    exp_t  q_exp[$];
    string q_nm[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    sc = 0, fc = 0;
    exp_t  m_e, m_a;
    string m_nm;

    function automatic in_t idle();
        in_t v;
        v = '0;
        return v;
    endfunction

    function automatic exp_t ex(input logic sf, sd, se, fd, fe, fm,
                                input logic [1:0] fa, fb,
                                input logic st, bs, vl, er);
        exp_t e;
        e = '0;
        e.stallf = sf; e.stalld = sd; e.stalle = se;
        e.flushd = fd; e.flushe = fe; e.flushm = fm;
        e.fa = fa; e.fb = fb;
        e.start = st; e.busy = bs; e.valid = vl; e.err = er;
        return e;
    endfunction

    // Drive one cycle of inputs, queue the expected outputs, advance the counter model.
    task automatic step(input logic rst_v, input in_t i, input exp_t e, input string nm);
        rst_n      = rst_v;
        rs1d       = i.rs1d;  rs2d = i.rs2d;
        rs1e       = i.rs1e;  rs2e = i.rs2e;  rde = i.rde;
        resultsrce = i.resultsrce;
        pcsrce     = i.pcsrce;
        rdm        = i.rdm;   regwritem = i.regwritem;
        rdw        = i.rdw;   regwritew = i.regwritew;
        mc_req_e   = i.mc_req_e;
        mc_done    = i.mc_done;
        clr_cnt    = i.clr_cnt;
        if (!rst_v) begin
            sc = 0;
            fc = 0;
        end
        e.scnt = CW'(sc);
        e.fcnt = CW'(fc);
        q_exp.push_back(e);
        q_nm.push_back(nm);
        if (rst_v) begin
            if (i.clr_cnt) begin
                sc = 0;
                fc = 0;
            end else begin
                if (e.stallf && sc < CMAX) sc++;
                if (e.flushd && fc < CMAX) fc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                m_e  = q_exp.pop_front();
                m_nm = q_nm.pop_front();
                m_a  = '0;
                m_a.stallf = stallf; m_a.stalld = stalld; m_a.stalle = stalle;
                m_a.flushd = flushd; m_a.flushe = flushe; m_a.flushm = flushm;
                m_a.fa = forwardae;  m_a.fb = forwardbe;
                m_a.start = mc_start; m_a.busy = mc_busy;
                m_a.valid = mc_valid; m_a.err = mc_err;
                m_a.scnt = stall_cnt; m_a.fcnt = flush_cnt;
                n_chk++;
                if (m_a !== m_e) begin
                    n_fail++;
                    $display("FAIL %s: actual {sf,sd,se,fd,fe,fm,fa,fb,st,bs,vl,er,scnt,fcnt}=%b required %b",
                             m_nm, m_a, m_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual time limit reached, required self termination");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t  v;
        exp_t z;
        exp_t bsy;
        z   = ex(0,0,0,0,0,0,2'b00,2'b00,0,0,0,0);
        bsy = ex(1,1,1,0,0,1,2'b00,2'b00,0,1,0,0);

        step(0, idle(), z, "reset");
        step(0, idle(), z, "reset_hold");
        step(1, idle(), z, "idle_after_reset");

        v = idle();
        v.rdm = 5; v.rdw = 5; v.rs1e = 5; v.rs2e = 5; v.regwritem = 1; v.regwritew = 1;
        step(1, v, ex(0,0,0,0,0,0,2'b10,2'b10,0,0,0,0), "fwd_mem_prio");
        v.rdm = 0;
        step(1, v, ex(0,0,0,0,0,0,2'b01,2'b01,0,0,0,0), "fwd_rdm_zero");
        v.rdm = 5; v.rs1e = 0;
        step(1, v, ex(0,0,0,0,0,0,2'b00,2'b10,0,0,0,0), "fwd_rs1e_zero");
        v.regwritem = 0; v.rs1e = 5;
        step(1, v, ex(0,0,0,0,0,0,2'b01,2'b01,0,0,0,0), "fwd_wb_only");

        v = idle(); v.resultsrce = 2'b01; v.rde = 7; v.rs2d = 7;
        step(1, v, ex(1,1,0,0,1,0,2'b00,2'b00,0,0,0,0), "lwstall_rs2");
        step(1, idle(), z, "after_lwstall");
        v.rs2d = 0; v.rs1d = 7;
        step(1, v, ex(1,1,0,0,1,0,2'b00,2'b00,0,0,0,0), "lwstall_rs1");
        v.rde = 0; v.rs1d = 0;
        step(1, v, z, "lw_rde_zero");

        v = idle(); v.pcsrce = 1;
        step(1, v, ex(0,0,0,1,1,0,2'b00,2'b00,0,0,0,0), "branch");
        v.resultsrce = 2'b01; v.rde = 7; v.rs1d = 7;
        step(1, v, ex(1,1,0,1,1,0,2'b00,2'b00,0,0,0,0), "branch_lwstall");
        v = idle(); v.mc_done = 1;
        step(1, v, z, "mc_done_in_idle");
        v = idle(); v.mc_req_e = 1; v.pcsrce = 1;
        step(1, v, ex(0,0,0,1,1,0,2'b00,2'b00,0,0,0,0), "mc_req_with_branch");

        // Multi-cycle op: done arrives four cycles after the start pulse.
        v = idle(); v.mc_req_e = 1;
        step(1, v, ex(1,1,1,0,0,1,2'b00,2'b00,1,0,0,0), "mc_start");
        step(1, v, bsy, "mc_busy1");
        step(1, v, bsy, "mc_busy2");
        v.pcsrce = 1; v.resultsrce = 2'b01; v.rde = 9; v.rs2d = 9;
        step(1, v, bsy, "mc_busy_masked");
        v = idle(); v.mc_req_e = 1; v.mc_done = 1;
        step(1, v, bsy, "mc_busy_done");
        v.mc_done = 0;
        step(1, v, ex(0,0,0,0,0,0,2'b00,2'b00,0,0,1,0), "mc_done_state");
        step(1, idle(), z, "mc_back_idle");

        // Timeout: no completion ever arrives.
        v = idle(); v.mc_req_e = 1;
        step(1, v, ex(1,1,1,0,0,1,2'b00,2'b00,1,0,0,0), "to_start");
        for (int k = 0; k < TO; k++) step(1, v, bsy, "to_busy");
        step(1, idle(), ex(0,0,0,0,0,0,2'b00,2'b00,0,0,1,1), "to_done_err");
        step(1, idle(), ex(0,0,0,0,0,0,2'b00,2'b00,0,0,0,1), "err_sticky");

        // Reset in the middle of a BUSY period.
        step(1, v, ex(1,1,1,0,0,1,2'b00,2'b00,1,0,0,1), "rb_start");
        step(1, v, ex(1,1,1,0,0,1,2'b00,2'b00,0,1,0,1), "rb_busy1");
        step(1, v, ex(1,1,1,0,0,1,2'b00,2'b00,0,1,0,1), "rb_busy2");
        step(0, idle(), z, "rst_mid_busy");
        step(1, idle(), z, "post_rst_no_start");

        // Completion on the same cycle the timeout would fire.
        step(1, v, ex(1,1,1,0,0,1,2'b00,2'b00,1,0,0,0), "co_start");
        for (int k = 0; k < TO - 1; k++) step(1, v, bsy, "co_busy");
        v.mc_done = 1;
        step(1, v, bsy, "co_busy_last_done");
        step(1, idle(), ex(0,0,0,0,0,0,2'b00,2'b00,0,0,1,0), "co_done_no_err");
        step(1, idle(), z, "co_idle");

        // Counter saturation, then clear taking priority over increment.
        v = idle(); v.resultsrce = 2'b01; v.rde = 3; v.rs1d = 3;
        for (int k = 0; k < 20; k++) step(1, v, ex(1,1,0,0,1,0,2'b00,2'b00,0,0,0,0), "sat_stall");
        v.pcsrce = 1;
        for (int k = 0; k < 18; k++) step(1, v, ex(1,1,0,1,1,0,2'b00,2'b00,0,0,0,0), "sat_both");
        v.clr_cnt = 1;
        step(1, v, ex(1,1,0,1,1,0,2'b00,2'b00,0,0,0,0), "clr_with_inc");
        step(1, idle(), z, "after_clr");
        step(1, idle(), z, "final_idle");

        for (int k = 0; k < 10 && q_exp.size() > 0; k++) @(posedge clk);
        if (q_exp.size() > 0) begin
            n_fail++;
            $display("FAIL drain: actual %0d entries left, required 0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
